// File: rtl/dual_port_memory.sv
// dual_port_memory: single-clock register-file RAM, write/read-back port 1 and read-only port 2
// Storage lives in sub-instance RAM (array ram); both read ports are registered, read-before-write.
module dual_port_memory_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int SIZE       = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] rdata2
);
  localparam logic [ADDR_WIDTH:0] SZ = (ADDR_WIDTH+1)'(SIZE);
  logic [DATA_WIDTH-1:0] ram [SIZE];
  logic w_ok, r1_ok, r2_ok;
  assign w_ok  = {1'b0, waddr} < SZ;
  assign r1_ok = {1'b0, raddr1} < SZ;
  assign r2_ok = {1'b0, raddr2} < SZ;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < SIZE; i++) ram[i] <= '0;
    else if (we && w_ok)
      ram[waddr] <= wdata;
  // out-of-range reads return zero instead of aliasing
  always_comb begin
    rdata1 = r1_ok ? ram[raddr1] : '0;
    rdata2 = r2_ok ? ram[raddr2] : '0;
  end
endmodule

module dual_port_memory #(
  parameter int DATA_WIDTH = 32,
  parameter int SIZE       = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  WE,
  input  logic [ADDR_WIDTH-1:0] ADDR1,
  input  logic [DATA_WIDTH-1:0] DI,
  input  logic [ADDR_WIDTH-1:0] ADDR2,
  output logic [DATA_WIDTH-1:0] DO1,
  output logic [DATA_WIDTH-1:0] DO2
);
  logic [DATA_WIDTH-1:0] rd1, rd2;
  dual_port_memory_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .SIZE(SIZE),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) RAM (
    .clk(CLK),
    .rst_n(RSTN),
    .we(WE),
    .waddr(ADDR1),
    .wdata(DI),
    .raddr1(ADDR1),
    .raddr2(ADDR2),
    .rdata1(rd1),
    .rdata2(rd2)
  );
  // registering the pre-write array contents gives read-before-write on collisions
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      DO1 <= '0;
      DO2 <= '0;
    end else begin
      DO1 <= rd1;
      DO2 <= rd2;
    end
endmodule

// File: tb/tb_dual_port_memory.sv
// tb_dual_port_memory: directed self-checking bench for dual_port_memory
module tb_dual_port_memory;
  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        WE = 1'b0;
  logic [2:0]  ADDR1 = '0;
  logic [31:0] DI = '0;
  logic [2:0]  ADDR2 = '0;
  logic [31:0] DO1, DO2;
  int checks = 0;
  int errors = 0;

  dual_port_memory #(.DATA_WIDTH(32), .SIZE(8), .ADDR_WIDTH(3)) dut (
    .CLK(CLK),
    .RSTN(RSTN),
    .WE(WE),
    .ADDR1(ADDR1),
    .DI(DI),
    .ADDR2(ADDR2),
    .DO1(DO1),
    .DO2(DO2)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    WE = 1'b1;
    ADDR1 = a;
    DI = d;
    tick();
    WE = 1'b0;
  endtask

  initial begin
    #3;
    chk("rst_do1", DO1, 32'd0);
    chk("rst_do2", DO2, 32'd0);
    tick();
    tick();
    RSTN = 1'b1;

    // basic write then read on both ports
    wr(3'd2, 32'd10);
    chk("wr_first_do1_old", DO1, 32'd0);
    ADDR2 = 3'd2;
    tick();
    chk("rd_do2_a2", DO2, 32'd10);
    chk("rd_do1_a2", DO1, 32'd10);

    // full sweep
    for (int i = 0; i < 8; i++) wr(3'(i), 32'hA5A50000 + 32'(i));
    DI = 32'hDEADBEEF;
    ADDR1 = 3'd4;
    repeat (3) tick();
    for (int i = 0; i < 8; i++) begin
      ADDR2 = 3'(i);
      tick();
      chk($sformatf("sweep_%0d", i), DO2, 32'hA5A50000 + 32'(i));
    end

    // collision: read-before-write
    wr(3'd5, 32'd1);
    WE = 1'b1;
    ADDR1 = 3'd5;
    DI = 32'd2;
    ADDR2 = 3'd5;
    tick();
    WE = 1'b0;
    chk("coll_do2_old", DO2, 32'd1);
    chk("coll_do1_old", DO1, 32'd1);
    tick();
    chk("coll_do2_new", DO2, 32'd2);
    chk("coll_do1_new", DO1, 32'd2);

    // dual independent read
    ADDR1 = 3'd3;
    ADDR2 = 3'd6;
    tick();
    chk("dual_do1", DO1, 32'hA5A50003);
    chk("dual_do2", DO2, 32'hA5A50006);

    // boundary words and neighbours
    wr(3'd7, 32'hFFFFFFFF);
    wr(3'd0, 32'h00000000);
    ADDR1 = 3'd7;
    ADDR2 = 3'd0;
    tick();
    chk("bnd_a7", DO1, 32'hFFFFFFFF);
    chk("bnd_a0", DO2, 32'h00000000);
    ADDR1 = 3'd6;
    ADDR2 = 3'd1;
    tick();
    chk("bnd_a6", DO1, 32'hA5A50006);
    chk("bnd_a1", DO2, 32'hA5A50001);

    // asynchronous reset mid-cycle
    ADDR1 = 3'd7;
    ADDR2 = 3'd6;
    tick();
    chk("pre_rst_do1", DO1, 32'hFFFFFFFF);
    #2;
    RSTN = 1'b0;
    #1;
    chk("async_do1", DO1, 32'd0);
    chk("async_do2", DO2, 32'd0);
    WE = 1'b1;
    ADDR1 = 3'd4;
    DI = 32'h12345678;
    tick();
    chk("hold_do1", DO1, 32'd0);
    WE = 1'b0;
    RSTN = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ADDR1 = 3'(i);
      ADDR2 = 3'(7 - i);
      tick();
      chk($sformatf("clr_p1_%0d", i), DO1, 32'd0);
      chk($sformatf("clr_p2_%0d", 7 - i), DO2, 32'd0);
    end

    // normal operation resumes after reset
    wr(3'd4, 32'hCAFEF00D);
    ADDR2 = 3'd4;
    tick();
    chk("post_rst_wr", DO2, 32'hCAFEF00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
